// File: rtl/partida_pkg.sv
// Shared types and constants for the game-level sequencer.
package partida_pkg;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        RODANDO    = 3'd1,
        PAUSADO    = 3'd2,
        VIOLACAO   = 3'd3,
        FIM_QUARTO = 3'd4,
        FIM_JOGO   = 3'd5
    } estado_t;

    localparam logic [4:0] SC_24 = 5'd24;
    localparam logic [4:0] SC_14 = 5'd14;

    localparam int unsigned MIN_W = 4;
    localparam int unsigned SEG_W = 6;
    localparam int unsigned QRT_W = 3;
    localparam int unsigned BUZ_W = 3;
    localparam int unsigned TOT_W = 10;

    // Remaining period time in seconds.
    function automatic logic [TOT_W-1:0] total_seg(input logic [MIN_W-1:0] m,
                                                   input logic [SEG_W-1:0] s);
        return TOT_W'(m) * TOT_W'(60) + TOT_W'(s);
    endfunction

endpackage

// File: rtl/controle_partida_contador_jogo.sv
// Period clock: mm:ss down counter with load, enable, tick and zero/last-second flags.
module contador_jogo
    import partida_pkg::*;
#(
    parameter int unsigned MIN_QUARTO = 10
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             carregar,
    input  logic             habilitar,
    input  logic             tick,
    output logic [MIN_W-1:0] minutos,
    output logic [SEG_W-1:0] segundos,
    output logic             zero_c,
    output logic             ultimo_c
);

    assign zero_c   = (minutos == '0) && (segundos == '0);
    assign ultimo_c = (minutos == '0) && (segundos == SEG_W'(1));

    always_ff @(posedge clock_in) begin
        if (reset || carregar) begin
            minutos  <= MIN_W'(MIN_QUARTO);
            segundos <= '0;
        end else if (habilitar && tick && !zero_c) begin
            if (segundos == '0) begin
                minutos  <= minutos - MIN_W'(1);
                segundos <= SEG_W'(59);
            end else begin
                segundos <= segundos - SEG_W'(1);
            end
        end
    end

endmodule

// File: rtl/controle_partida.sv
// Game sequencer: period clock, quarter count, shot-clock control and shared buzzer.
// Optional SC_DESLIGA_EN: suppress shot-clock reloads when less period time remains.
module controle_partida
    import partida_pkg::*;
#(
    parameter int unsigned MIN_QUARTO  = 10,
    parameter int unsigned NUM_QUARTOS = 4,
    parameter int unsigned BUZZ_TICKS  = 3
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             tick,
    input  logic             btn_iniciar,
    input  logic             btn_pausar,
    input  logic             evt_posse,
    input  logic             evt_rebote,
    input  logic             sc_zero,
    output logic             sc_carga24,
    output logic             sc_carga14,
    output logic             sc_rodar,
    output logic [MIN_W-1:0] minutos,
    output logic [SEG_W-1:0] segundos,
    output logic [QRT_W-1:0] quarto,
    output logic [2:0]       estado,
    output logic             buzzer
);

    estado_t          state, state_next;
    logic             carga24_c, carga14_c, carregar_c, buzina_c, desliga_c;
    logic             inicia_c, fim_c, zero_c, ultimo_c, recarga_pend_c;
    logic             desligado;
    logic [BUZ_W-1:0] buz_cnt, buz_next;

    contador_jogo #(.MIN_QUARTO(MIN_QUARTO)) u_contador (
        .clock_in  (clock_in),
        .reset     (reset),
        .carregar  (carregar_c),
        .habilitar (state == RODANDO),
        .tick      (tick),
        .minutos   (minutos),
        .segundos  (segundos),
        .zero_c    (zero_c),
        .ultimo_c  (ultimo_c)
    );

    assign estado   = state;
    assign inicia_c = btn_iniciar && !btn_pausar;
    assign fim_c    = zero_c || (tick && ultimo_c);
    // sc_zero is stale until a just-issued reload reaches the shot clock.
    assign recarga_pend_c = sc_carga24 || sc_carga14;

`ifdef SC_DESLIGA_EN
    logic [TOT_W-1:0] restante_c;
    assign restante_c = total_seg(minutos, segundos);
`endif

    always_ff @(posedge clock_in) begin
        if (reset) state <= OCIOSO;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        carga24_c  = 1'b0;
        carga14_c  = 1'b0;
        carregar_c = 1'b0;
        buzina_c   = 1'b0;
        desliga_c  = 1'b0;
        case (state)
            OCIOSO: begin
                if (inicia_c) begin
                    state_next = RODANDO;
                    carga24_c  = 1'b1;
                end
            end
            RODANDO: begin
                if (fim_c) begin
                    state_next = (quarto == QRT_W'(NUM_QUARTOS)) ? FIM_JOGO : FIM_QUARTO;
                    buzina_c   = 1'b1;
                end else if (sc_zero && !recarga_pend_c && !desligado) begin
                    state_next = VIOLACAO;
                    buzina_c   = 1'b1;
                end else if (btn_pausar) begin
                    state_next = PAUSADO;
                end
                if (evt_posse)       carga24_c = 1'b1;
                else if (evt_rebote) carga14_c = 1'b1;
            end
            PAUSADO: begin
                if (inicia_c) state_next = RODANDO;
                if (evt_posse)       carga24_c = 1'b1;
                else if (evt_rebote) carga14_c = 1'b1;
            end
            VIOLACAO: begin
                if (evt_posse) begin
                    state_next = PAUSADO;
                    carga24_c  = 1'b1;
                end
            end
            FIM_QUARTO: begin
                if (inicia_c) begin
                    state_next = PAUSADO;
                    carga24_c  = 1'b1;
                    carregar_c = 1'b1;
                end
            end
            FIM_JOGO: begin
                state_next = FIM_JOGO;
            end
            default: state_next = OCIOSO;
        endcase
`ifdef SC_DESLIGA_EN
        // A new quarter reloads against a fresh period, so it is never suppressed.
        if (!carregar_c) begin
            if (carga24_c && (restante_c < TOT_W'(SC_24))) begin
                carga24_c = 1'b0;
                desliga_c = 1'b1;
            end
            if (carga14_c && (restante_c < TOT_W'(SC_14))) begin
                carga14_c = 1'b0;
                desliga_c = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        buz_next = buz_cnt;
        if (buzina_c)                     buz_next = BUZ_W'(BUZZ_TICKS);
        else if (tick && buz_cnt != '0)   buz_next = buz_cnt - BUZ_W'(1);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            quarto     <= QRT_W'(1);
            buz_cnt    <= '0;
            buzzer     <= 1'b0;
            sc_rodar   <= 1'b0;
            sc_carga24 <= 1'b0;
            sc_carga14 <= 1'b0;
            desligado  <= 1'b0;
        end else begin
            buz_cnt    <= buz_next;
            buzzer     <= (buz_next != '0);
            sc_rodar   <= (state == RODANDO) && !desligado;
            sc_carga24 <= carga24_c;
            sc_carga14 <= carga14_c;
            if (carregar_c) begin
                quarto    <= quarto + QRT_W'(1);
                desligado <= 1'b0;
            end else if (desliga_c) begin
                desligado <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_controle_partida.sv
// Directed bench for controle_partida (short quarters) plus a default-parameter reset check.
module tb_controle_partida;

    localparam int unsigned MIN_Q = 1;

    logic       clock_in = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, btn_iniciar = 1'b0, btn_pausar = 1'b0;
    logic       evt_posse = 1'b0, evt_rebote = 1'b0, sc_zero = 1'b0;
    logic       sc_carga24, sc_carga14, sc_rodar, buzzer;
    logic [3:0] minutos;
    logic [5:0] segundos;
    logic [2:0] quarto, estado;
    logic       d_c24, d_c14, d_rodar, d_buzzer;
    logic [3:0] d_minutos;
    logic [5:0] d_segundos;
    logic [2:0] d_quarto, d_estado;

    int checks = 0;
    int errors = 0;

    controle_partida #(.MIN_QUARTO(MIN_Q), .NUM_QUARTOS(4), .BUZZ_TICKS(3)) dut (
        .clock_in(clock_in), .reset(reset), .tick(tick),
        .btn_iniciar(btn_iniciar), .btn_pausar(btn_pausar),
        .evt_posse(evt_posse), .evt_rebote(evt_rebote), .sc_zero(sc_zero),
        .sc_carga24(sc_carga24), .sc_carga14(sc_carga14), .sc_rodar(sc_rodar),
        .minutos(minutos), .segundos(segundos), .quarto(quarto),
        .estado(estado), .buzzer(buzzer)
    );

    controle_partida dut_def (
        .clock_in(clock_in), .reset(reset), .tick(tick),
        .btn_iniciar(btn_iniciar), .btn_pausar(btn_pausar),
        .evt_posse(evt_posse), .evt_rebote(evt_rebote), .sc_zero(sc_zero),
        .sc_carga24(d_c24), .sc_carga14(d_c14), .sc_rodar(d_rodar),
        .minutos(d_minutos), .segundos(d_segundos), .quarto(d_quarto),
        .estado(d_estado), .buzzer(d_buzzer)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: inputs set before the call are sampled, then pulses are cleared.
    task automatic step();
        @(posedge clock_in);
        #1;
        tick = 1'b0; btn_iniciar = 1'b0; btn_pausar = 1'b0;
        evt_posse = 1'b0; evt_rebote = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            step();
        end
    endtask

    function automatic logic [31:0] clk_s();
        return 32'(minutos) * 32'd60 + 32'(segundos);
    endfunction

    initial begin
        step(); step();
        reset = 1'b0;
        check("rst_estado", 32'(estado), 0);
        check("rst_min", 32'(minutos), MIN_Q);
        check("rst_seg", 32'(segundos), 0);
        check("rst_quarto", 32'(quarto), 1);
        check("rst_buzzer", 32'(buzzer), 0);
        check("rst_rodar", 32'(sc_rodar), 0);
        check("rst_c24", 32'(sc_carga24), 0);
        check("rst_c14", 32'(sc_carga14), 0);
        check("rst_def_min", 32'(d_minutos), 10);

        // Quarter 1: full run to 0:00
        btn_iniciar = 1'b1; step();
        check("start_estado", 32'(estado), 1);
        check("start_c24", 32'(sc_carga24), 1);
        step();
        check("start_c24_width", 32'(sc_carga24), 0);
        check("start_rodar", 32'(sc_rodar), 1);
        for (int i = 1; i <= 60; i++) begin
            tick = 1'b1; step();
            check("q1_clock", clk_s(), 32'(60 - i));
            check("q1_no_c24", 32'(sc_carga24), 0);
        end
        check("q1_estado", 32'(estado), 4);
        check("q1_buz_on", 32'(buzzer), 1);
        ticks(1); check("q1_buz_t1", 32'(buzzer), 1);
        ticks(1); check("q1_buz_t2", 32'(buzzer), 1);
        ticks(1); check("q1_buz_t3", 32'(buzzer), 0);
        check("q1_hold_estado", 32'(estado), 4);
        check("q1_hold_clock", clk_s(), 0);
        check("q1_rodar", 32'(sc_rodar), 0);

        // Quarter 2: reload arbitration, violation, pause priority
        btn_iniciar = 1'b1; step();
        check("q2_quarto", 32'(quarto), 2);
        check("q2_clock", clk_s(), 60);
        check("q2_estado", 32'(estado), 2);
        check("q2_c24", 32'(sc_carga24), 1);
        btn_iniciar = 1'b1; step();
        check("q2_run", 32'(estado), 1);
        step();
        evt_posse = 1'b1; evt_rebote = 1'b1; step();
        check("both_c24", 32'(sc_carga24), 1);
        check("both_c14", 32'(sc_carga14), 0);
        step();
        check("both_c24_width", 32'(sc_carga24), 0);
        check("both_c14_late", 32'(sc_carga14), 0);
        evt_rebote = 1'b1; step();
        check("reb_c14", 32'(sc_carga14), 1);
        check("reb_c24", 32'(sc_carga24), 0);
        step();
        ticks(55);
        check("q2_clock_5", clk_s(), 5);
        sc_zero = 1'b1; step();
        check("viol_estado", 32'(estado), 3);
        check("viol_buz", 32'(buzzer), 1);
        step();
        check("viol_rodar", 32'(sc_rodar), 0);
        ticks(1);
        check("viol_clock", clk_s(), 5);
        check("viol_hold", 32'(estado), 3);
        evt_posse = 1'b1; sc_zero = 1'b0; step();
        check("viol_c24", 32'(sc_carga24), 1);
        check("viol_to_paus", 32'(estado), 2);
        check("viol_buz_cont", 32'(buzzer), 1);
        ticks(1); check("viol_buz_t2", 32'(buzzer), 1);
        ticks(1); check("viol_buz_t3", 32'(buzzer), 0);
        check("paus_clock", clk_s(), 5);
        btn_iniciar = 1'b1; step();
        check("resume", 32'(estado), 1);
        btn_iniciar = 1'b1; btn_pausar = 1'b1; step();
        check("pause_wins", 32'(estado), 2);
        btn_iniciar = 1'b1; step();
        ticks(5);
        check("q2_end", 32'(estado), 4);
        check("q2_end_clock", clk_s(), 0);

        // Quarter 3: late possession change
        btn_iniciar = 1'b1; step();
        btn_iniciar = 1'b1; step();
        ticks(40);
        check("q3_clock_20", clk_s(), 20);
        evt_posse = 1'b1; step();
`ifdef SC_DESLIGA_EN
        check("opt_c24", 32'(sc_carga24), 0);
        step();
        check("opt_rodar", 32'(sc_rodar), 0);
`else
        check("opt_c24", 32'(sc_carga24), 1);
        step();
        check("opt_rodar", 32'(sc_rodar), 1);
`endif
        ticks(20);
        check("q3_end", 32'(estado), 4);
        check("q3_quarto", 32'(quarto), 3);

        // Quarter 4: final tick coincident with shot-clock zero
        btn_iniciar = 1'b1; step();
        btn_iniciar = 1'b1; step();
        check("q4_quarto", 32'(quarto), 4);
        ticks(59);
        check("q4_clock_1", clk_s(), 1);
        tick = 1'b1; sc_zero = 1'b1; step();
        check("fj_estado", 32'(estado), 5);
        check("fj_clock", clk_s(), 0);
        check("fj_buz", 32'(buzzer), 1);
        btn_iniciar = 1'b1; step();
        check("fj_ignore_start", 32'(estado), 5);
        check("fj_quarto", 32'(quarto), 4);
        sc_zero = 1'b0;
        ticks(3);
        check("fj_buz_off", 32'(buzzer), 0);

        // Reset in the middle of a running period
        reset = 1'b1; step(); reset = 1'b0;
        btn_iniciar = 1'b1; step();
        ticks(30);
        check("mid_clock", clk_s(), 30);
        check("mid_def_clock", 32'(d_minutos) * 32'd60 + 32'(d_segundos), 570);
        reset = 1'b1; step(); reset = 1'b0;
        check("mid_rst_estado", 32'(estado), 0);
        check("mid_rst_clock", clk_s(), 60);
        check("mid_rst_quarto", 32'(quarto), 1);
        check("mid_rst_buz", 32'(buzzer), 0);
        check("mid_rst_def_min", 32'(d_minutos), 10);
        check("mid_rst_def_seg", 32'(d_segundos), 0);
        check("mid_rst_def_estado", 32'(d_estado), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
